// File: rtl/dsp_pkg.sv
// Shared definitions for the MAC slice: opmode field positions, Z-select codes
// and the pre-adder width rule.
package dsp_pkg;

    localparam int OP_PRE_SUB  = 0;
    localparam int OP_PRE_BYP  = 1;
    localparam int OP_ZSEL_LO  = 2;
    localparam int OP_ZSEL_HI  = 3;
    localparam int OP_POST_SUB = 4;

    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_C    = 2'b01;
    localparam logic [1:0] Z_P    = 2'b10;

    // One guard bit over the wider pre-adder operand so D+/-B never truncates.
    function automatic int prew(input int bw, input int dw);
        return ((bw > dw) ? bw : dw) + 1;
    endfunction

endpackage

// File: rtl/dsp_preadd.sv
// Registered signed pre-adder stage: D+B, D-B, or sign-extended B on bypass.
module dsp_preadd
    import dsp_pkg::*;
#(
    parameter int BW   = 18,
    parameter int DW   = 18,
    parameter int PREW = prew(BW, DW)
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            ce,
    input  logic [BW-1:0]   b,
    input  logic [DW-1:0]   d,
    input  logic            pre_sub,
    input  logic            pre_byp,
    output logic [PREW-1:0] pre
);

    logic signed [PREW-1:0] b_x;
    logic signed [PREW-1:0] d_x;
    logic signed [PREW-1:0] pre_nxt;

    assign b_x = PREW'($signed(b));
    assign d_x = PREW'($signed(d));

    always_comb begin
        pre_nxt = d_x + b_x;
        if (pre_byp) begin
            pre_nxt = b_x;
        end else if (pre_sub) begin
            pre_nxt = d_x - b_x;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            pre <= '0;
        end else if (ce) begin
            pre <= pre_nxt;
        end
    end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Four-stage signed DSP slice: input regs, pre-adder, multiplier, post-adder/accumulator
// with per-sample opmode, valid pipeline, global clock enable and overflow flag.
module dsp_mac_pipe
    import dsp_pkg::*;
#(
    parameter int AW = 18,
    parameter int BW = 18,
    parameter int DW = 18,
    parameter int CW = 48,
    parameter int PW = 48
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          ce,
    input  logic          in_valid,
    input  logic [AW-1:0] A,
    input  logic [BW-1:0] B,
    input  logic [DW-1:0] D,
    input  logic [CW-1:0] C,
    input  logic [4:0]    opmode,
    output logic [PW-1:0] P,
    output logic          out_valid,
    output logic          overflow
);

    localparam int PREW = prew(BW, DW);
    localparam int MW   = AW + PREW;

    generate
        if (CW > PW || PW < MW) begin : g_bad_params
            $error("dsp_mac_pipe: parameters need CW <= PW and PW >= AW + max(BW,DW) + 1");
        end
    endgenerate

    // S1: input capture
    logic [AW-1:0] a1;
    logic [BW-1:0] b1;
    logic [DW-1:0] d1;
    logic [CW-1:0] c1;
    logic [4:0]    op1;
    logic          v1;

    // S2/S3 carry only the post-adder controls: {post_sub, zsel}
    logic [AW-1:0]   a2;
    logic [CW-1:0]   c2;
    logic [2:0]      op2;
    logic            v2;
    logic [PREW-1:0] pre2;

    logic [MW-1:0]   m3;
    logic [CW-1:0]   c3;
    logic [2:0]      op3;
    logic            v3;

    logic signed [MW-1:0] m_nxt;
    logic signed [PW-1:0] z;
    logic signed [PW:0]   z_x;
    logic signed [PW:0]   m_x;
    logic signed [PW:0]   sum;

    always_ff @(posedge CLK) begin
        if (rst) begin
            a1  <= '0;
            b1  <= '0;
            d1  <= '0;
            c1  <= '0;
            op1 <= '0;
            v1  <= 1'b0;
        end else if (ce) begin
            a1  <= A;
            b1  <= B;
            d1  <= D;
            c1  <= C;
            op1 <= opmode;
            v1  <= in_valid;
        end
    end

    dsp_preadd #(
        .BW (BW),
        .DW (DW)
    ) u_preadd (
        .CLK     (CLK),
        .rst     (rst),
        .ce      (ce),
        .b       (b1),
        .d       (d1),
        .pre_sub (op1[OP_PRE_SUB]),
        .pre_byp (op1[OP_PRE_BYP]),
        .pre     (pre2)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            a2  <= '0;
            c2  <= '0;
            op2 <= '0;
            v2  <= 1'b0;
        end else if (ce) begin
            a2  <= a1;
            c2  <= c1;
            op2 <= {op1[OP_POST_SUB], op1[OP_ZSEL_HI:OP_ZSEL_LO]};
            v2  <= v1;
        end
    end

    // Full-width product; MW bits always hold it exactly.
    assign m_nxt = MW'($signed(a2)) * MW'($signed(pre2));

    always_ff @(posedge CLK) begin
        if (rst) begin
            m3  <= '0;
            c3  <= '0;
            op3 <= '0;
            v3  <= 1'b0;
        end else if (ce) begin
            m3  <= m_nxt;
            c3  <= c2;
            op3 <= op2;
            v3  <= v2;
        end
    end

    always_comb begin
        z = '0;
        case (op3[1:0])
            Z_ZERO:  z = '0;
            Z_C:     z = PW'($signed(c3));
            Z_P:     z = $signed(P);
            default: z = '0;
        endcase
    end

    // One extra bit keeps the exact result so overflow is just a sign-bit disagreement.
    assign z_x = (PW+1)'(z);
    assign m_x = (PW+1)'($signed(m3));
    assign sum = op3[2] ? (z_x - m_x) : (z_x + m_x);

    always_ff @(posedge CLK) begin
        if (rst) begin
            P         <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= v3;
            if (v3) begin
                P        <= sum[PW-1:0];
                overflow <= sum[PW] ^ sum[PW-1];
            end
        end
    end

endmodule
